// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies 160 bytes from {src_hi,8'h00} into OAM and fences the CPU
// off the MMU bus (HRAM excepted) while the copy is running.
module oam_dma_controller #(
   parameter int CYCLES_PER_BYTE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_read_en,
   input  logic        cpu_write_en,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_wait,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_read_en,
   output logic        mem_write_en,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        oam_write_en,
   output logic        dma_active
);

   localparam int PW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 2;
   localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
   localparam logic [PW-1:0] PH_LATCH = PW'(1);
   localparam logic [PW-1:0] PH_WRITE = PW'(2);
   localparam logic [7:0]    IDX_LAST = 8'd159;

   typedef enum logic [1:0] {IDLE, START, XFER} state_t;

   state_t        state, state_nxt;
   logic [7:0]    index, index_nxt;
   logic [PW-1:0] phase, phase_nxt;
   logic [7:0]    src_hi, src_hi_nxt;
   logic [7:0]    dma_reg, dma_reg_nxt;
   logic [7:0]    latch, latch_nxt;
   logic          restart, restart_nxt;

   logic ff46_sel, ff46_wr, hram_sel, blocking, dma_slot, fwd;

   assign ff46_sel = (cpu_addr == 16'hFF46);
   assign ff46_wr  = cpu_write_en && ff46_sel;
   assign hram_sel = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         index   <= '0;
         phase   <= '0;
         src_hi  <= '0;
         dma_reg <= 8'hFF;
         latch   <= '0;
         restart <= 1'b0;
      end else begin
         state   <= state_nxt;
         index   <= index_nxt;
         phase   <= phase_nxt;
         src_hi  <= src_hi_nxt;
         dma_reg <= dma_reg_nxt;
         latch   <= latch_nxt;
         restart <= restart_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      index_nxt   = index;
      phase_nxt   = phase;
      src_hi_nxt  = src_hi;
      dma_reg_nxt = dma_reg;
      latch_nxt   = latch;
      restart_nxt = restart;
      case (state)
         START: begin
            if (phase == PH_LAST) begin
               state_nxt = XFER;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase + 1'b1;
            end
         end
         XFER: begin
            if (phase == PH_LATCH) latch_nxt = mem_rdata;
            if (phase == PH_LAST) begin
               phase_nxt = '0;
               if (index == IDX_LAST) begin
                  state_nxt   = IDLE;
                  index_nxt   = '0;
                  restart_nxt = 1'b0;
               end else begin
                  index_nxt = index + 8'd1;
               end
            end else begin
               phase_nxt = phase + 1'b1;
            end
         end
         default: ;
      endcase
      // A new FF46 write restarts the copy from any state; echo RAM sources fold down by 0x20.
      if (ff46_wr) begin
         dma_reg_nxt = cpu_wdata;
         src_hi_nxt  = (cpu_wdata >= 8'hE0) ? cpu_wdata - 8'h20 : cpu_wdata;
         index_nxt   = '0;
         phase_nxt   = '0;
         state_nxt   = START;
         restart_nxt = (state == XFER) || ((state == START) && restart);
      end
   end

   assign blocking = (state == XFER) || ((state == START) && restart);
   assign dma_slot = (state == XFER) && (phase == '0);
   assign fwd      = !blocking || hram_sel;

   always_comb begin
      mem_addr     = cpu_addr;
      mem_wdata    = cpu_wdata;
      mem_read_en  = fwd && cpu_read_en && !ff46_sel;
      mem_write_en = fwd && cpu_write_en;
      cpu_rdata    = fwd ? mem_rdata : 8'hFF;
      cpu_wait     = 1'b0;
      if (ff46_sel) cpu_rdata = dma_reg;
      // The DMA read slot owns the bus; an HRAM access in that cycle must be held.
      if (dma_slot) begin
         mem_addr     = {src_hi, index};
         mem_read_en  = 1'b1;
         mem_write_en = 1'b0;
         cpu_wait     = hram_sel && (cpu_read_en || cpu_write_en);
      end
   end

   assign oam_write_en = (state == XFER) && (phase == PH_WRITE);
   assign oam_addr     = index;
   assign oam_wdata    = latch;
   assign dma_active   = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: timing model keyed on cycles since the last FF46 write,
// plus directed scenarios with literal expectations.
module tb_oam_dma_controller;
   localparam int CPB = 4;
   localparam int ACT = 161 * CPB;

   logic        clk = 1'b0, reset = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_read_en = 1'b0, cpu_write_en = 1'b0;
   logic [7:0]  cpu_rdata;
   logic        cpu_wait;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_read_en, mem_write_en;
   logic [7:0]  mem_rdata = '0;
   logic [7:0]  oam_addr, oam_wdata;
   logic        oam_write_en, dma_active;

   int checks = 0, errors = 0;

   oam_dma_controller #(.CYCLES_PER_BYTE(CPB)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read_en(cpu_read_en),
      .cpu_write_en(cpu_write_en), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_en(mem_read_en),
      .mem_write_en(mem_write_en), .mem_rdata(mem_rdata),
      .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write_en(oam_write_en),
      .dma_active(dma_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // MMU: data returned one cycle after the read strobe.
   always @(posedge clk) if (mem_read_en) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

   // Model state: the copy is a pure function of time since the last FF46 write.
   int         cyc = 0, e_cyc = -100000;
   bit         have = 0, rst_m = 0;
   logic [7:0] src_m = '0, dreg_m = 8'hFF;

   always @(posedge clk or negedge reset) begin
      int t_old;
      if (!reset) begin
         have = 0; rst_m = 0; dreg_m = 8'hFF;
      end else begin
         if (cpu_write_en && cpu_addr == 16'hFF46) begin
            t_old  = cyc - e_cyc;
            rst_m  = have && t_old < ACT && (t_old >= CPB || rst_m);
            have   = 1;
            e_cyc  = cyc + 1;
            dreg_m = cpu_wdata;
            src_m  = (cpu_wdata >= 8'hE0) ? cpu_wdata - 8'h20 : cpu_wdata;
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      int t, k, ko;
      bit act, blk, dslot, hram, ff46, ow, fwd, e_rd, e_wr, e_wait;
      logic [15:0] e_addr;
      logic [7:0]  e_rdata;
      if (reset) begin
         t     = cyc - e_cyc;
         act   = have && t >= 0 && t < ACT;
         blk   = act && (t >= CPB || rst_m);
         dslot = act && t >= CPB && (t % CPB) == 0;
         k     = (t - CPB) / CPB;
         ow    = act && t >= CPB + 2 && ((t - CPB - 2) % CPB) == 0;
         ko    = (t - CPB - 2) / CPB;
         hram  = cpu_addr >= 16'hFF80 && cpu_addr <= 16'hFFFE;
         ff46  = cpu_addr == 16'hFF46;
         fwd   = !blk || hram;
         e_wait = 0;
         if (dslot) begin
            e_rd = 1; e_wr = 0; e_addr = {src_m, 8'(k)};
            e_wait = hram && (cpu_read_en || cpu_write_en);
         end else begin
            e_rd = fwd && cpu_read_en && !ff46; e_wr = fwd && cpu_write_en; e_addr = cpu_addr;
         end
         e_rdata = ff46 ? dreg_m : (fwd ? mem_rdata : 8'hFF);
         chk("dma_active", dma_active, act);
         chk("oam_write_en", oam_write_en, ow);
         if (ow) begin
            chk("oam_addr", oam_addr, ko);
            chk("oam_wdata", oam_wdata, 8'(ko) ^ 8'h5A);
         end
         chk("mem_read_en", mem_read_en, e_rd);
         chk("mem_write_en", mem_write_en, e_wr);
         chk("cpu_wait", cpu_wait, e_wait);
         if (e_rd || e_wr) chk("mem_addr", mem_addr, e_addr);
         if (e_wr) chk("mem_wdata", mem_wdata, cpu_wdata);
         if (cpu_read_en && !e_wait) chk("cpu_rdata", cpu_rdata, e_rdata);
      end
   end

   // Pulse counting and timing capture relative to the latest FF46 write.
   int oam_cnt = 0, first_t = -1, last_act_t = -1;
   always @(negedge clk) begin
      if (reset && oam_write_en) begin
         oam_cnt++;
         if (oam_cnt == 1) first_t = cyc - e_cyc;
      end
      if (reset && dma_active) last_act_t = cyc - e_cyc;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle_bus();
      cpu_read_en = 0; cpu_write_en = 0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
   endtask

   task automatic write_ff46(input logic [7:0] v);
      cpu_addr = 16'hFF46; cpu_wdata = v; cpu_write_en = 1; cpu_read_en = 0;
      step();
      idle_bus();
   endtask

   task automatic wait_t(input int target);
      for (int i = 0; i < 2000 && (cyc - e_cyc) != target; i++) step();
      chk("wait_t", cyc - e_cyc, target);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 2000 && dma_active; i++) step();
      chk("done_timeout", dma_active, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      cpu_addr = 16'hFF46; cpu_read_en = 1;
      @(negedge clk);
      chk("rst_dma_active", dma_active, 1'b0);
      chk("rst_oam_we", oam_write_en, 1'b0);
      chk("rst_cpu_wait", cpu_wait, 1'b0);
      chk("rst_ff46", cpu_rdata, 8'hFF);
      idle_bus();
      reset = 1;
      step();

      // Full copy from C100 with CPU traffic injected mid-transfer
      oam_cnt = 0;
      write_ff46(8'hC1);
      wait_t(44);                     // phase0 of index 10
      cpu_addr = 16'hFF90; cpu_read_en = 1;
      @(negedge clk);
      chk("hram_wait", cpu_wait, 1'b1);
      chk("dma_addr_10", mem_addr, 16'hC10A);
      step();
      @(negedge clk);
      chk("hram_fwd_wait", cpu_wait, 1'b0);
      chk("hram_fwd_rd", mem_read_en, 1'b1);
      chk("hram_fwd_addr", mem_addr, 16'hFF90);
      step();
      @(negedge clk);
      chk("hram_data", cpu_rdata, 8'hCA);
      step();
      cpu_addr = 16'h8000; cpu_read_en = 1;
      @(negedge clk);
      chk("blk_rd_data", cpu_rdata, 8'hFF);
      chk("blk_rd_en", mem_read_en, 1'b0);
      step();
      cpu_read_en = 0; cpu_addr = 16'hC000; cpu_wdata = 8'h12; cpu_write_en = 1;
      @(negedge clk);
      chk("blk_wr_en", mem_write_en, 1'b0);
      step();
      cpu_write_en = 0; cpu_addr = 16'hFF46; cpu_read_en = 1;
      @(negedge clk);
      chk("ff46_rd", cpu_rdata, 8'hC1);
      step();
      idle_bus();
      wait_done();
      chk("oam_count", oam_cnt, 160);
      chk("first_oam_t", first_t, 6);
      chk("active_end_t", last_act_t + 1, 644);
      step();

      // Restart at index 80, landing on its OAM-write cycle
      oam_cnt = 0;
      write_ff46(8'hC1);
      wait_t(326);
      cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_write_en = 1;
      step();
      idle_bus();
      chk("restart_cnt", oam_cnt, 81);
      step();
      cpu_addr = 16'h8000; cpu_read_en = 1;
      @(negedge clk);
      chk("restart_blk", cpu_rdata, 8'hFF);
      chk("restart_blk_rd", mem_read_en, 1'b0);
      chk("restart_active", dma_active, 1'b1);
      step();
      idle_bus();
      oam_cnt = 0;
      wait_done();
      chk("restart_oam_count", oam_cnt, 160);
      chk("restart_end_t", cyc - e_cyc, ACT);
      step();

      // Echo-region source remap
      write_ff46(8'hFE);
      wait_t(4);
      @(negedge clk);
      chk("remap_first", mem_addr, 16'hDE00);
      wait_t(640);
      @(negedge clk);
      chk("remap_last", mem_addr, 16'hDE9F);
      wait_done();
      step();

      // Reset mid-copy
      write_ff46(8'hC1);
      wait_t(100);
      reset = 0;
      #1;
      chk("midrst_active", dma_active, 1'b0);
      chk("midrst_oam_we", oam_write_en, 1'b0);
      cpu_addr = 16'hFF46; cpu_read_en = 1;
      #1;
      chk("midrst_ff46", cpu_rdata, 8'hFF);
      step();
      chk("midrst_active2", dma_active, 1'b0);
      idle_bus();
      reset = 1;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
